// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - traffic lamp sequence monitor with sticky fault causes and cycle counter
// Tracks RED->GREEN->YELLOW->RED, bounds each lamp's dwell and latches the first fault cause.
module traffic_light_monitor #(
    parameter int MAX_DWELL = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             clr,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             fault,
    output logic             err_onehot,
    output logic             err_order,
    output logic             err_timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int DW = $clog2(MAX_DWELL + 2);

    localparam logic [1:0] PH_RED    = 2'b00;
    localparam logic [1:0] PH_GREEN  = 2'b01;
    localparam logic [1:0] PH_YELLOW = 2'b10;
    localparam logic [1:0] PH_NONE   = 2'b11;

    typedef enum logic [2:0] {SYNC, RED, GREEN, YELLOW, FAULT} state_t;

    state_t        state;
    state_t        next_state;
    logic [DW-1:0] dwell;
    logic [2:0]    lamps;
    logic          one_hot;
    logic          same_lamp;
    logic          next_lamp;
    logic [1:0]    next_phase;

    // lamps is ordered {red, green, yellow} so the legal successor is a ring rotation
    always_comb begin
        lamps      = {red, green, yellow};
        one_hot    = $onehot(lamps);
        same_lamp  = 1'b0;
        next_lamp  = 1'b0;
        next_state = FAULT;
        next_phase = PH_NONE;
        case (state)
            RED: begin
                same_lamp  = (lamps == 3'b100);
                next_lamp  = (lamps == 3'b010);
                next_state = GREEN;
                next_phase = PH_GREEN;
            end
            GREEN: begin
                same_lamp  = (lamps == 3'b010);
                next_lamp  = (lamps == 3'b001);
                next_state = YELLOW;
                next_phase = PH_YELLOW;
            end
            YELLOW: begin
                same_lamp  = (lamps == 3'b001);
                next_lamp  = (lamps == 3'b100);
                next_state = RED;
                next_phase = PH_RED;
            end
            default: begin
                same_lamp = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= SYNC;
            dwell       <= '0;
            cycle_count <= '0;
            fault       <= 1'b0;
            err_onehot  <= 1'b0;
            err_order   <= 1'b0;
            err_timeout <= 1'b0;
            phase       <= PH_NONE;
            locked      <= 1'b0;
        end else if (clr) begin
            state       <= SYNC;
            dwell       <= '0;
            fault       <= 1'b0;
            err_onehot  <= 1'b0;
            err_order   <= 1'b0;
            err_timeout <= 1'b0;
            phase       <= PH_NONE;
            locked      <= 1'b0;
        end else begin
            case (state)
                SYNC: begin
                    if (lamps == 3'b100) begin
                        state  <= RED;
                        dwell  <= DW'(1);
                        phase  <= PH_RED;
                        locked <= 1'b1;
                    end
                end
                RED, GREEN, YELLOW: begin
                    if (!one_hot) begin
                        state      <= FAULT;
                        fault      <= 1'b1;
                        err_onehot <= 1'b1;
                        phase      <= PH_NONE;
                        locked     <= 1'b0;
                    end else if (next_lamp) begin
                        state <= next_state;
                        dwell <= DW'(1);
                        phase <= next_phase;
                        if (state == YELLOW && cycle_count != '1)
                            cycle_count <= cycle_count + CNT_W'(1);
                    end else if (!same_lamp) begin
                        state     <= FAULT;
                        fault     <= 1'b1;
                        err_order <= 1'b1;
                        phase     <= PH_NONE;
                        locked    <= 1'b0;
                    end else if (dwell >= DW'(MAX_DWELL)) begin
                        state       <= FAULT;
                        fault       <= 1'b1;
                        err_timeout <= 1'b1;
                        phase       <= PH_NONE;
                        locked      <= 1'b0;
                    end else begin
                        dwell <= dwell + DW'(1);
                    end
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - randomized bench for traffic_light_monitor against a lamp-ring model
module tb_traffic_light_monitor;

    localparam int MAXD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, red, yellow, green, clr;
    logic [1:0] ph [2];
    logic       lk [2];
    logic       flt[2];
    logic       eo [2];
    logic       er [2];
    logic       et [2];
    logic [7:0] cc0;
    logic [1:0] cc1;

    int checks   = 0;
    int failures = 0;

    traffic_light_monitor #(.MAX_DWELL(MAXD), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .red(red), .yellow(yellow), .green(green), .clr(clr),
        .phase(ph[0]), .locked(lk[0]), .fault(flt[0]), .err_onehot(eo[0]),
        .err_order(er[0]), .err_timeout(et[0]), .cycle_count(cc0)
    );

    traffic_light_monitor #(.MAX_DWELL(MAXD), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .red(red), .yellow(yellow), .green(green), .clr(clr),
        .phase(ph[1]), .locked(lk[1]), .fault(flt[1]), .err_onehot(eo[1]),
        .err_order(er[1]), .err_timeout(et[1]), .cycle_count(cc1)
    );

    // Model: st = -1 unsynced, 0/1/2 = lamp index on the ring red,green,yellow, 3 = faulted
    int m_st [2];
    int m_dw [2];
    int m_cnt[2];
    bit m_eo [2];
    bit m_er [2];
    bit m_et [2];
    int cnt_max[2] = '{255, 3};
    bit model_valid = 1'b0;

    always @(posedge clk) begin
        int n;
        int idx;
        n   = int'(red) + int'(green) + int'(yellow);
        idx = red ? 0 : (green ? 1 : 2);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_st[k] = -1; m_dw[k] = 0; m_cnt[k] = 0;
                m_eo[k] = 0; m_er[k] = 0; m_et[k] = 0;
            end else if (clr) begin
                m_st[k] = -1; m_dw[k] = 0;
                m_eo[k] = 0; m_er[k] = 0; m_et[k] = 0;
            end else if (m_st[k] == -1) begin
                if (n == 1 && red) begin
                    m_st[k] = 0; m_dw[k] = 1;
                end
            end else if (m_st[k] < 3) begin
                if (n != 1) begin
                    m_eo[k] = 1; m_st[k] = 3;
                end else if (idx == (m_st[k] + 1) % 3) begin
                    if (m_st[k] == 2 && m_cnt[k] < cnt_max[k]) m_cnt[k] = m_cnt[k] + 1;
                    m_st[k] = idx; m_dw[k] = 1;
                end else if (idx != m_st[k]) begin
                    m_er[k] = 1; m_st[k] = 3;
                end else if (m_dw[k] + 1 > MAXD) begin
                    m_et[k] = 1; m_st[k] = 3;
                end else begin
                    m_dw[k] = m_dw[k] + 1;
                end
            end
        end
        if (!rst_n) model_valid = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            for (int k = 0; k < 2; k++) begin
                bit trk;
                trk = (m_st[k] >= 0 && m_st[k] <= 2);
                check($sformatf("phase%0d", k), 32'(ph[k]), trk ? m_st[k] : 3);
                check($sformatf("locked%0d", k), 32'(lk[k]), 32'(trk));
                check($sformatf("fault%0d", k), 32'(flt[k]), 32'(m_st[k] == 3));
                check($sformatf("err_onehot%0d", k), 32'(eo[k]), 32'(m_eo[k]));
                check($sformatf("err_order%0d", k), 32'(er[k]), 32'(m_er[k]));
                check($sformatf("err_timeout%0d", k), 32'(et[k]), 32'(m_et[k]));
                check($sformatf("cycle_count%0d", k), (k == 0) ? 32'(cc0) : 32'(cc1), m_cnt[k]);
            end
        end
    end

    task automatic step(input bit r, input bit g, input bit y, input bit c, input bit rs);
        red = r; green = g; yellow = y; clr = c; rst_n = rs;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic lamp(input int code);
        step(code == 0, code == 1, code == 2, 1'b0, 1'b1);
    endtask

    initial begin
        step(0, 0, 0, 0, 0);
        check("reset_phase", 32'(ph[0]), 3);
        check("reset_locked", 32'(lk[0]), 0);
        check("reset_fault", 32'(flt[0]), 0);
        check("reset_count", 32'(cc0), 0);

        for (int i = 0; i < 7; i++) begin
            lamp(i % 3);
            if (i == 0) check("lock_first_red", 32'(lk[0]), 1);
        end
        check("two_cycles_count", 32'(cc0), 2);
        check("two_cycles_count_narrow", 32'(cc1), 2);
        check("two_cycles_fault", 32'(flt[0]), 0);
        check("two_cycles_phase", 32'(ph[0]), 0);

        step(0, 0, 0, 1, 1);
        repeat (4) lamp(0);
        check("dwell4_no_fault", 32'(flt[0]), 0);
        lamp(0);
        check("timeout_flag", 32'(et[0]), 1);
        check("timeout_fault", 32'(flt[0]), 1);
        check("timeout_phase", 32'(ph[0]), 3);

        step(0, 0, 0, 1, 1);
        repeat (4) lamp(0);
        lamp(1);
        check("dwell_max_then_green_fault", 32'(flt[0]), 0);
        check("dwell_max_then_green_phase", 32'(ph[0]), 1);

        step(0, 0, 0, 1, 1);
        lamp(0);
        lamp(2);
        check("order_flag", 32'(er[0]), 1);
        check("order_onehot", 32'(eo[0]), 0);
        check("order_timeout", 32'(et[0]), 0);
        repeat (3) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1);
        check("order_sticky", 32'(er[0]), 1);
        check("order_sticky_onehot", 32'(eo[0]), 0);

        step(0, 0, 0, 1, 1);
        lamp(0);
        step(1, 1, 0, 0, 1);
        check("onehot_flag", 32'(eo[0]), 1);
        check("onehot_order", 32'(er[0]), 0);
        check("onehot_timeout", 32'(et[0]), 0);
        step(0, 0, 0, 1, 1);
        check("clr_fault", 32'(flt[0]), 0);
        check("clr_onehot", 32'(eo[0]), 0);
        check("clr_phase", 32'(ph[0]), 3);
        check("clr_keeps_count", 32'(cc0), 2);

        lamp(0);
        repeat (5) begin
            lamp(1); lamp(2); lamp(0);
        end
        check("sat_narrow", 32'(cc1), 3);
        check("wide_count", 32'(cc0), 7);

        lamp(1);
        check("mid_green_phase", 32'(ph[0]), 1);
        step(1, 0, 1, 1, 0);
        check("rst_phase", 32'(ph[0]), 3);
        check("rst_locked", 32'(lk[0]), 0);
        check("rst_fault", 32'(flt[0]), 0);
        check("rst_count", 32'(cc0), 0);
        check("rst_count_narrow", 32'(cc1), 0);

        repeat (3000) begin
            int r;
            int code;
            bit c;
            bit rs;
            logic [2:0] p;
            r  = int'($urandom_range(0, 99));
            c  = ($urandom_range(0, 99) < 3) || (m_st[0] == 3 && r < 20);
            rs = ($urandom_range(0, 199) != 0);
            if (m_st[0] >= 0 && m_st[0] <= 2)
                code = (r < 60) ? (m_st[0] + 1) % 3 : ((r < 90) ? m_st[0] : -1);
            else
                code = (r < 70) ? 0 : -1;
            if (code == -1) begin
                p = 3'($urandom_range(0, 7));
                step(p[2], p[1], p[0], c, rs);
            end else begin
                step(code == 0, code == 1, code == 2, c, rs);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 The block SHALL have parameter MAX_DWELL, default 4, meaning the maximum consecutive cycles one lamp may stay lit (legal range 1..255).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the completed-cycle counter.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 red  input  1  observed red lamp.
REQ-007 yellow  input  1  observed yellow lamp.
REQ-008 green  input  1  observed green lamp.
REQ-009 clr  input  1  synchronous fault clear and resynchronise request.
REQ-010 phase  output  2  tracked phase: 00 RED, 01 GREEN, 10 YELLOW, 11 none.
REQ-011 locked  output  1  high while tracking a legal sequence.
REQ-012 fault  output  1  sticky fault indication.
REQ-013 err_onehot  output  1  sticky cause: lamps not exactly one-hot.
REQ-014 err_order  output  1  sticky cause: illegal phase transition.
REQ-015 err_timeout  output  1  sticky cause: dwell exceeded MAX_DWELL.
REQ-016 cycle_count  output  CNT_W  number of completed RED->GREEN->YELLOW->RED cycles.

Function
REQ-017 The block SHALL sample red/yellow/green on every rising clk edge and act on them in the same edge; all outputs are registered, giving one-cycle latency.
REQ-018 The FSM SHALL have states SYNC, RED, GREEN, YELLOW and FAULT.
REQ-019 Legal order SHALL be RED->GREEN->YELLOW->RED only.
REQ-020 SYNC: if only red is lit, go to RED with dwell=1; any other input pattern, including illegal ones, keeps SYNC and raises no error.
REQ-021 RED/GREEN/YELLOW: if the lamp pattern is not exactly one-hot, set err_onehot and go to FAULT.
REQ-022 RED/GREEN/YELLOW: if the same lamp is still lit, increment dwell; if dwell would exceed MAX_DWELL, set err_timeout and go to FAULT.
REQ-023 RED/GREEN/YELLOW: if the next legal lamp is lit, move to that state with dwell=1.
REQ-024 RED/GREEN/YELLOW: any other single lamp (e.g. RED->YELLOW, GREEN->RED) SHALL set err_order and go to FAULT.
REQ-025 Error priority within one cycle SHALL be onehot > order > timeout; exactly one cause flag is set per fault entry.
REQ-026 FAULT SHALL hold fault and its cause flag high, ignore the lamps and record no further causes until clr or reset.
REQ-027 Every YELLOW->RED transition SHALL increment cycle_count by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-028 The dwell counter SHALL be wide enough to hold MAX_DWELL+1 without overflow.
REQ-029 clr high in any state SHALL clear fault and all err_* flags and go to SYNC next cycle; cycle_count is retained.
REQ-030 If clr and an error condition occur in the same cycle, clr SHALL win and no flag is set.
REQ-031 phase SHALL read 11 and locked SHALL read 0 in SYNC and FAULT; locked SHALL read 1 in RED, GREEN and YELLOW.

Reset
REQ-032 rst_n low at a clk edge SHALL force SYNC, dwell=0, cycle_count=0, fault=0, all err_*=0, phase=11 and locked=0, overriding clr and any mid-cycle operation.
REQ-033 The first tracking after reset SHALL require a red-only sample.

Verification
REQ-034 Reset, then lamps R,G,Y,R,G,Y,R, one cycle each -> locked=1 from the 2nd edge, cycle_count=2, fault=0.
REQ-035 MAX_DWELL=4, lamps red for 5 consecutive cycles after sync -> err_timeout=1, fault=1, phase=11 on the 5th edge; red for exactly 4 cycles then green -> no fault.
REQ-036 Lamps R then Y -> err_order=1, err_onehot=0, err_timeout=0; the flag stays set while the lamps keep changing.
REQ-037 Lamps R then R+G simultaneously -> err_onehot=1 only; the next cycle pulses clr -> all flags 0, phase=11, cycle_count unchanged.
REQ-038 CNT_W=2, run 5 full cycles -> cycle_count saturates at 3.
REQ-039 Mid-GREEN drive rst_n=0 together with clr=1 and an illegal lamp -> next cycle all outputs are at reset values.
